// File: rtl/delay_scheduler_pkg.sv
// Shared delay-line definitions: scheduler state encodings and the derivation
// of counter width and pulse-generator hold-off from the clocking plan.
package delay_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EVAL  = 2'd1,
    ST_POP   = 2'd2,
    ST_FLUSH = 2'd3
  } sched_state_e;

  // Clocking plan of the delay line.
  localparam int unsigned CLK_HZ         = 100_000_000;
  localparam int unsigned MOD_HZ         = 10_000_000;
  localparam int unsigned PULSE_COUNT    = 12;
  localparam int unsigned MAX_DELAY_CLKS = 200_000;

  // Pulse generator is busy for pulse count x clocks per modulation period.
  function automatic int unsigned holdoff_cycles(input int unsigned clk_hz,
                                                 input int unsigned mod_hz,
                                                 input int unsigned pulses);
    return pulses * (clk_hz / mod_hz);
  endfunction

  localparam int unsigned DEF_CTR_WIDTH      = $clog2(MAX_DELAY_CLKS);
  localparam int unsigned DEF_HOLDOFF_CYCLES = holdoff_cycles(CLK_HZ, MOD_HZ, PULSE_COUNT);
  localparam int unsigned DEF_LATE_WINDOW    = 1024;

  // Width of the saturating overlap-drop counter.
  localparam int unsigned DROP_CNT_W = 16;

endpackage

// File: rtl/delay_scheduler_holdoff_timer.sv
// Hold-off timer: loads CYCLES-1 on a trigger, counts down to zero and
// saturates there; idle_o is high whenever the count is zero.
module holdoff_timer #(
  parameter int unsigned CYCLES = 120
) (
  input  logic clk,
  input  logic n_reset,
  input  logic load_i,
  output logic idle_o
);

  localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  // Next count: load on trigger, otherwise decrement toward zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = LOAD_VAL;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register; reset abandons any hold-off in progress.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign idle_o = (count_q == '0);

endmodule

// File: rtl/delay_scheduler.sv
// Delay-line scheduler: compares the timestamp FIFO head against the running
// counter, pops entries as they fall due, fires the pulse generator outside
// its hold-off, drops entries that fall due during hold-off, and drains the
// FIFO without firing while a flush is requested.
//
// FIFO handshake: fifo_data is valid whenever fifo_empty is low; a one-cycle
// fifo_rden pulse consumes the head, which is replaced on the following clock.
// The scheduler never examines the head in the cycle it pops, so pops are at
// least two cycles apart.
module delay_scheduler
  import delay_scheduler_pkg::*;
#(
  parameter int unsigned CTR_WIDTH      = DEF_CTR_WIDTH,
  parameter int unsigned HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
  parameter int unsigned LATE_WINDOW    = DEF_LATE_WINDOW
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic [CTR_WIDTH-1:0]  ctr,
  input  logic                  fifo_empty,
  input  logic [CTR_WIDTH-1:0]  fifo_data,
  output logic                  fifo_rden,
  input  logic                  flush_req,
  output logic                  flush_busy,
  output logic                  trigger,
  output logic                  late_fire,
  output logic                  overlap_drop,
  output logic [DROP_CNT_W-1:0] drop_count,
  output sched_state_e          state_dbg
);

  localparam logic [CTR_WIDTH-1:0] LATE_W = CTR_WIDTH'(LATE_WINDOW);

  sched_state_e          state_q;
  logic                  trigger_q, late_q, drop_q, rden_q;
  logic [DROP_CNT_W-1:0] drop_count_q, drop_count_d;

  logic [CTR_WIDTH-1:0] diff;
  logic                 due, holdoff_idle, eval_go, fire_d, drop_d, late_d;

  // Modular distance from the timestamp to now; small values mean "due".
  assign diff    = ctr - fifo_data;
  assign due     = !fifo_empty && (diff < LATE_W);
  assign eval_go = (state_q == ST_EVAL) && !flush_req && due;
  assign fire_d  = eval_go && holdoff_idle;
  assign drop_d  = eval_go && !holdoff_idle;
  assign late_d  = fire_d && (diff != '0);

  // Saturating count of entries discarded because of hold-off.
  always_comb begin
    drop_count_d = drop_count_q;
    if (drop_d && (drop_count_q != {DROP_CNT_W{1'b1}})) begin
      drop_count_d = drop_count_q + 1'b1;
    end
  end

  holdoff_timer #(
    .CYCLES (HOLDOFF_CYCLES)
  ) u_holdoff (
    .clk     (clk),
    .n_reset (n_reset),
    .load_i  (fire_d),
    .idle_o  (holdoff_idle)
  );

  // Scheduler FSM with registered strobes; all strobes default low each cycle.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= ST_IDLE;
      trigger_q    <= 1'b0;
      late_q       <= 1'b0;
      drop_q       <= 1'b0;
      rden_q       <= 1'b0;
      drop_count_q <= '0;
    end else begin
      trigger_q    <= 1'b0;
      late_q       <= 1'b0;
      drop_q       <= 1'b0;
      rden_q       <= 1'b0;
      drop_count_q <= drop_count_d;
      case (state_q)
        ST_IDLE: begin
          if (flush_req) begin
            state_q <= ST_FLUSH;
          end else if (!fifo_empty) begin
            state_q <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (flush_req) begin
            state_q <= ST_FLUSH;
          end else if (fifo_empty) begin
            state_q <= ST_IDLE;
          end else if (due) begin
            trigger_q <= fire_d;
            late_q    <= late_d;
            drop_q    <= drop_d;
            rden_q    <= 1'b1;
            state_q   <= ST_POP;
          end
        end
        ST_POP: begin
          state_q <= fifo_empty ? ST_IDLE : ST_EVAL;
        end
        ST_FLUSH: begin
          // The cycle after a pop is a settle cycle while the head updates.
          if (!rden_q) begin
            if (!fifo_empty) begin
              rden_q <= 1'b1;
            end else if (!flush_req) begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign fifo_rden    = rden_q;
  assign trigger      = trigger_q;
  assign late_fire    = late_q;
  assign overlap_drop = drop_q;
  assign drop_count   = drop_count_q;
  assign flush_busy   = (state_q == ST_FLUSH);
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_delay_scheduler.sv
// Bench for delay_scheduler with an 8-bit counter, hold-off of 10 clocks and
// a late window of 16. A show-ahead FIFO model feeds the DUT; directed
// scenarios push expected output events into exp_q and an independent
// monitor compares every trigger / drop / pop the DUT presents.
module tb_delay_scheduler;

  localparam int CW = 8;
  localparam int EW = 28;  // {trigger, drop, rden, late, ctr[7:0], drop_count[15:0]}

  localparam logic [2:0] K_TRIG = 3'b101;
  localparam logic [2:0] K_DROP = 3'b011;
  localparam logic [2:0] K_FPOP = 3'b001;

  logic          clk;
  logic          n_reset;
  logic [CW-1:0] ctr;
  logic          fifo_empty;
  logic [CW-1:0] fifo_data;
  logic          fifo_rden;
  logic          flush_req;
  logic          flush_busy;
  logic          trigger;
  logic          late_fire;
  logic          overlap_drop;
  logic [15:0]   drop_count;
  logic [1:0]    state_dbg;

  logic [CW-1:0] fifo_q[$];
  logic [EW-1:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  delay_scheduler #(
    .CTR_WIDTH      (CW),
    .HOLDOFF_CYCLES (10),
    .LATE_WINDOW    (16)
  ) dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .ctr          (ctr),
    .fifo_empty   (fifo_empty),
    .fifo_data    (fifo_data),
    .fifo_rden    (fifo_rden),
    .flush_req    (flush_req),
    .flush_busy   (flush_busy),
    .trigger      (trigger),
    .late_fire    (late_fire),
    .overlap_drop (overlap_drop),
    .drop_count   (drop_count),
    .state_dbg    (state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic refresh_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? '0 : fifo_q[0];
  endtask

  task automatic push(input logic [CW-1:0] ts);
    fifo_q.push_back(ts);
    refresh_fifo();
  endtask

  task automatic clear_fifo();
    fifo_q.delete();
    refresh_fifo();
  endtask

  // One clock: remember whether this cycle pops, then after the edge apply
  // the pop and advance the counter.
  task automatic tick();
    logic rden_seen;
    @(negedge clk);
    rden_seen = fifo_rden;
    @(posedge clk);
    #1;
    if (rden_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
    ctr = ctr + 1'b1;
    refresh_fifo();
  endtask

  task automatic run_to(input logic [CW-1:0] target);
    int n;
    n = 0;
    while (ctr != target && n < 300) begin
      tick();
      n++;
    end
    if (ctr != target) begin
      errors++;
      $display("FAIL run_to: counter at %0d, required %0d", ctr, target);
    end
  endtask

  task automatic expect_ev(input logic [2:0] kind, input logic late,
                           input int c, input int dc);
    logic [7:0]  c8;
    logic [15:0] dc16;
    c8   = c[7:0];
    dc16 = dc[15:0];
    exp_q.push_back({kind, late, c8, dc16});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0d, required %0d", name, act, req);
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected events never seen, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, " trigger"},      32'(trigger), 0);
    check({name, " fifo_rden"},    32'(fifo_rden), 0);
    check({name, " late_fire"},    32'(late_fire), 0);
    check({name, " overlap_drop"}, 32'(overlap_drop), 0);
    check({name, " flush_busy"},   32'(flush_busy), 0);
    check({name, " drop_count"},   32'(drop_count), 0);
    check({name, " state"},        32'(state_dbg), 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [EW-1:0] act, e;
    forever begin
      @(negedge clk);
      if (n_reset && (trigger || overlap_drop || fifo_rden)) begin
        act = {trigger, overlap_drop, fifo_rden, late_fire, ctr, drop_count};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL event: unexpected kind=%b late=%b ctr=%0d dc=%0d, required none",
                   act[27:25], act[24], act[23:16], act[15:0]);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            errors++;
            $display("FAIL event: actual kind=%b late=%b ctr=%0d dc=%0d, required kind=%b late=%b ctr=%0d dc=%0d",
                     act[27:25], act[24], act[23:16], act[15:0],
                     e[27:25], e[24], e[23:16], e[15:0]);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_reset   = 1'b0;
    ctr       = '0;
    flush_req = 1'b0;
    clear_fifo();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    n_reset = 1'b1;

    // 1: single on-time entry
    ctr = 8'd40;
    push(8'd50);
    expect_ev(K_TRIG, 1'b0, 51, 0);
    run_to(8'd65);
    check_drained("t1 on-time");

    // 2: second entry falls due during hold-off
    ctr = 8'd40;
    push(8'd50);
    push(8'd55);
    expect_ev(K_TRIG, 1'b0, 51, 0);
    expect_ev(K_DROP, 1'b0, 56, 1);
    run_to(8'd80);
    check("t2 drop_count", 32'(drop_count), 1);
    check_drained("t2 overlap");

    // 3a: entry near the top of the counter range
    ctr = 8'd245;
    push(8'd250);
    expect_ev(K_TRIG, 1'b0, 251, 1);
    run_to(8'd20);
    check_drained("t3a near wrap");

    // 3b: entry written before wrap, due after wrap
    ctr = 8'd250;
    push(8'd3);
    expect_ev(K_TRIG, 1'b0, 4, 1);
    run_to(8'd30);
    check_drained("t3b across wrap");

    // 4a: late but inside the window
    ctr = 8'd25;
    push(8'd20);
    expect_ev(K_TRIG, 1'b1, 27, 1);
    run_to(8'd45);
    check_drained("t4a late");

    // 4b: outside the window -> held as future, then flushed away
    ctr = 8'd60;
    push(8'd20);
    run_to(8'd90);
    check("t4b held", 32'(fifo_q.size()), 1);
    flush_req = 1'b1;
    expect_ev(K_FPOP, 1'b0, 92, 1);
    run_to(8'd94);
    check("t4b flush_busy", 32'(flush_busy), 1);
    tick();
    flush_req = 1'b0;
    tick();
    check("t4b exit flush", 32'(flush_busy), 0);
    check_drained("t4b future");

    // 5: flush requested as the head becomes due
    ctr = 8'd100;
    push(8'd105);
    push(8'd106);
    push(8'd107);
    run_to(8'd105);
    flush_req = 1'b1;
    expect_ev(K_FPOP, 1'b0, 107, 1);
    expect_ev(K_FPOP, 1'b0, 109, 1);
    expect_ev(K_FPOP, 1'b0, 111, 1);
    tick();
    check("t5 flush_busy", 32'(flush_busy), 1);
    run_to(8'd115);
    check("t5 fifo drained", 32'(fifo_q.size()), 0);
    check("t5 still busy", 32'(flush_busy), 1);
    flush_req = 1'b0;
    tick();
    check("t5 idle", 32'(state_dbg), 0);
    check("t5 drop_count", 32'(drop_count), 1);
    check_drained("t5 flush");

    // 6a: reset during hold-off, then fire inside the old hold-off window
    ctr = 8'd120;
    push(8'd125);
    run_to(8'd126);
    check("t6a trigger", 32'(trigger), 1);
    n_reset = 1'b0;
    #1;
    check_all_zero("t6a reset");
    clear_fifo();
    tick();
    tick();
    n_reset = 1'b1;
    push(8'd130);
    expect_ev(K_TRIG, 1'b0, 131, 0);
    run_to(8'd145);
    check_drained("t6a after reset");

    // 6b: reset mid-flush
    ctr = 8'd150;
    push(8'd200);
    push(8'd201);
    push(8'd202);
    flush_req = 1'b1;
    expect_ev(K_FPOP, 1'b0, 152, 0);
    expect_ev(K_FPOP, 1'b0, 154, 0);
    run_to(8'd155);
    check("t6b flush_busy", 32'(flush_busy), 1);
    n_reset   = 1'b0;
    flush_req = 1'b0;
    #1;
    check_all_zero("t6b reset");
    clear_fifo();
    tick();
    tick();
    n_reset = 1'b1;
    repeat (10) tick();
    check("t6b stays idle", 32'(state_dbg), 0);
    check_drained("t6b flush");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
